// File: rtl/mult_div.sv
// mult_div: iterative signed 32-bit multiply/divide unit with HI/LO result registers.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        MultCtrl,
    input  logic        DivCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        MultOut,
    output logic        DivOut,
    output logic        divZero
);
    typedef enum logic [2:0] {IDLE, MRUN, DRUN, FIX, RELEASE} state_t;
    state_t state, nxt;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] rem, quo, opr;
    logic        sa, sb, is_div;
    logic        start_mult, start_div, zero_div, fix_mult, fix_div;
    logic [31:0] mag_a, mag_b, r_fix, q_fix, rem_sub;
    logic [32:0] msum;
    logic [63:0] prod;
    logic        ge;
    assign mag_a   = A[31] ? -A : A;
    assign mag_b   = B[31] ? -B : B;
    assign msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opr} : 33'd0);
    // the shifted partial remainder is 33 bits; a successful subtract always fits back in 32
    assign ge      = {rem, quo[31]} >= {1'b0, opr};
    assign rem_sub = {rem[30:0], quo[31]} - opr;
    assign prod    = (sa ^ sb) ? -acc : acc;
    assign q_fix   = (sa ^ sb) ? -quo : quo;
    assign r_fix   = sa ? -rem : rem;
    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else        state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = DivCtrl ? (B == 32'd0 ? RELEASE : DRUN) : (MultCtrl ? MRUN : IDLE);
            MRUN:    nxt = count == 6'd31 ? FIX : MRUN;
            DRUN:    nxt = count == 6'd31 ? FIX : DRUN;
            FIX:     nxt = RELEASE;
            RELEASE: nxt = (!MultCtrl && !DivCtrl) ? IDLE : RELEASE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        start_mult = state == IDLE && MultCtrl && !DivCtrl;
        start_div  = state == IDLE && DivCtrl && B != 32'd0;
        zero_div   = state == IDLE && DivCtrl && B == 32'd0;
        fix_mult   = state == FIX && !is_div;
        fix_div    = state == FIX && is_div;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            {HI, LO, acc}             <= '0;
            {rem, quo, opr, count}    <= '0;
            {sa, sb, is_div}          <= '0;
            {MultOut, DivOut, divZero} <= '0;
        end else begin
            MultOut <= fix_mult;
            DivOut  <= fix_div;
            divZero <= zero_div;
            if (start_mult || start_div) begin
                sa     <= A[31];
                sb     <= B[31];
                is_div <= start_div;
                count  <= 6'd0;
                opr    <= start_div ? mag_b : mag_a;
                acc    <= {32'd0, mag_b};
                rem    <= 32'd0;
                quo    <= mag_a;
            end else if (state == MRUN || state == DRUN) begin
                count <= count + 6'd1;
                if (state == MRUN) acc <= {msum, acc[31:1]};
                else begin
                    rem <= ge ? rem_sub : {rem[30:0], quo[31]};
                    quo <= {quo[30:0], ge};
                end
            end
            if (fix_mult) {HI, LO} <= prod;
            if (fix_div) begin
                LO <= q_fix;
                HI <= r_fix;
            end
        end
    end
endmodule

// File: doc/mult_div.md
# mult_div

Iterative signed 32-bit multiply/divide unit serving the multicycle control unit. It is started by the control unit's MultCtrl/DivCtrl strobes, takes operands from the register-file A/B latches, and writes results into its own HI/LO registers. It reports completion (MultOut/DivOut) or division by zero (divZero) back to the control unit. The mfhi/mflo paths read HI/LO directly.

## Interface
- No parameters; width fixed at 32 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- MultCtrl  in  1  multiply request (level; held by control unit until MultOut seen).
- DivCtrl  in  1  divide request (level; held until DivOut or divZero seen).
- A  in  32  operand rs (multiplicand / dividend), two's complement.
- B  in  32  operand rt (multiplier / divisor), two's complement.
- HI  out  32  product bits [63:32] / remainder.
- LO  out  32  product bits [31:0] / quotient.
- MultOut  out  1  one-cycle multiply-done pulse.
- DivOut  out  1  one-cycle divide-done pulse.
- divZero  out  1  one-cycle divide-by-zero pulse.

## Operation
- States: IDLE, MRUN, DRUN, FIX, RELEASE.
- IDLE: on edge with DivCtrl=1 (DivCtrl wins if both high):
  - B==0 → divZero=1, go RELEASE, HI/LO untouched.
  - else latch |A|, |B|, sign flags, count=0 → DRUN.
- IDLE with only MultCtrl=1: latch magnitudes and signs → MRUN.
- MRUN: 32 iterations of unsigned shift-add on 64-bit accumulator (one bit per cycle, LSB first).
- DRUN: 32 iterations of unsigned restoring division (one quotient bit per cycle, MSB first); 33-bit partial remainder.
- count: 6-bit; after the 32nd iteration → FIX.
- FIX, multiply:
  - product negated if sign(A)^sign(B).
  - HI←[63:32], LO←[31:0]; MultOut=1.
- FIX, divide:
  - quotient negated if sign(A)^sign(B).
  - remainder takes sign of A.
  - LO←quotient, HI←remainder; DivOut=1.
- -2^31 / -1 → LO=0x80000000, HI=0; no error flag.
- -2^31 operands: magnitude 0x80000000 treated as unsigned; results are correct modulo 2^64 / 2^32.
- RELEASE:
  - holds until MultCtrl=0 and DivCtrl=0, then → IDLE.
  - prevents re-trigger from strobes still high after done.
- Requests arriving in MRUN/DRUN/FIX/RELEASE are ignored; operands sampled only at the start edge, so later A/B changes have no effect.
- HI/LO change only in FIX or reset; they hold otherwise, including across divZero.

## Timing
- Reset (reset=0 at an edge): state=IDLE; HI=LO=0; MultOut=DivOut=divZero=0; count=0; accumulators cleared.
- Reset has priority in every state; an operation in progress is aborted with no done pulse.
- Edge N samples the start strobe:
  - edges N+1..N+32: iterations.
  - edge N+33: FIX writes HI/LO and sets the done flag.
  - HI/LO and MultOut/DivOut are visible during cycle N+33→N+34; the pulse clears at N+34.
  - latency 34 cycles from start edge to done.
- divZero: set at edge N, visible for cycle N→N+1 only.
- At most one of MultOut/DivOut/divZero is high in any cycle.
- Earliest new start: the first edge after both strobes are seen low in RELEASE (state is IDLE at that edge, start sampled on the following edge).

## Test plan
- Multiply: A=7, B=-3 (0xFFFFFFFD), MultCtrl high → at start+34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, MultOut one cycle.
- Multiply: A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- Divide: A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, DivOut at start+34.
- Divide: A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero:
  - stimulus: HI/LO preloaded by a prior multiply, then A=5, B=0.
  - response: divZero high one cycle after start edge; no DivOut; HI/LO unchanged.
- Strobe handling:
  - MultCtrl held high 3 cycles past MultOut → no second operation starts; RELEASE exits after drop.
  - reset asserted at iteration 10 → all outputs 0, no done pulse; a fresh divide afterwards completes correctly in 34 cycles.
